// File: rtl/line_buffer_ctrl.sv
// Line buffer sequencer: writes rows round-robin into four external buffers and streams 3x3 windows from three of them.
// Window output is registered (1 cycle); reads stall on i_out_ready, and the source is never backpressured (o_overflow flags loss).
module line_buffer_ctrl #(
  parameter int IMAGE_WIDTH = 512
) (
  input  logic        clk,
  input  logic        rstN,
  input  logic [7:0]  i_pixel_data,
  input  logic        i_pixel_data_valid,
  input  logic        i_out_ready,
  input  logic [95:0] lb_rd_data,
  output logic [3:0]  lb_data_valid,
  output logic [3:0]  lb_rd_enable,
  output logic [71:0] o_pixel_data,
  output logic        o_pixel_data_valid,
  output logic        o_intr,
  output logic        o_overflow
);

  localparam int CW = $clog2(IMAGE_WIDTH);
  localparam int TW = $clog2(4 * IMAGE_WIDTH) + 1;
  localparam logic [CW-1:0] LAST_COL = CW'(IMAGE_WIDTH - 1);
  localparam logic [TW-1:0] CNT_FULL = TW'(4 * IMAGE_WIDTH);
  localparam logic [TW-1:0] CNT_3ROW = TW'(3 * IMAGE_WIDTH);

  typedef enum logic {IDLE, READ} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] wr_cnt, rd_cnt;
  logic [1:0]    wr_sel, rd_sel;
  logic [TW-1:0] total_cnt;
  logic          rd_fire, row_done;
  logic [23:0]   lb_row [4];
  logic [71:0]   window;
  logic          unused_pixel;

  // Pixel data goes straight to the buffers outside this block.
  assign unused_pixel = ^i_pixel_data;

  assign rd_fire  = (state == READ) && i_out_ready;
  assign row_done = rd_fire && (rd_cnt == LAST_COL);

  always_comb begin
    lb_data_valid = '0;
    lb_rd_enable  = '0;
    lb_data_valid[wr_sel] = i_pixel_data_valid;
    if (rd_fire) begin
      lb_rd_enable[rd_sel]        = 1'b1;
      lb_rd_enable[rd_sel + 2'd1] = 1'b1;
      lb_rd_enable[rd_sel + 2'd2] = 1'b1;
    end
  end

  always_comb begin
    for (int k = 0; k < 4; k++) begin
      lb_row[k] = lb_rd_data[95 - 24*k -: 24];
    end
    window = {lb_row[rd_sel], lb_row[rd_sel + 2'd1], lb_row[rd_sel + 2'd2]};
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (total_cnt >= CNT_3ROW) state_nxt = READ;
      READ: if (row_done) state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state              <= IDLE;
      wr_cnt             <= '0;
      rd_cnt             <= '0;
      wr_sel             <= '0;
      rd_sel             <= '0;
      total_cnt          <= '0;
      o_pixel_data       <= '0;
      o_pixel_data_valid <= 1'b0;
      o_intr             <= 1'b0;
      o_overflow         <= 1'b0;
    end else begin
      state <= state_nxt;

      if (i_pixel_data_valid) begin
        if (wr_cnt == LAST_COL) begin
          wr_cnt <= '0;
          wr_sel <= wr_sel + 2'd1;
        end else begin
          wr_cnt <= wr_cnt + CW'(1);
        end
      end

      if (rd_fire) begin
        if (row_done) begin
          rd_cnt <= '0;
          rd_sel <= rd_sel + 2'd1;
        end else begin
          rd_cnt <= rd_cnt + CW'(1);
        end
      end

      // A write into a full set is still forwarded; the count saturates.
      if (i_pixel_data_valid && !rd_fire) begin
        if (total_cnt == CNT_FULL) o_overflow <= 1'b1;
        else                       total_cnt  <= total_cnt + TW'(1);
      end else if (rd_fire && !i_pixel_data_valid) begin
        total_cnt <= total_cnt - TW'(1);
      end

      o_intr             <= row_done;
      o_pixel_data_valid <= rd_fire;
      if (rd_fire) o_pixel_data <= window;
    end
  end

endmodule

// File: tb/tb_line_buffer_ctrl.sv
// Bench for line_buffer_ctrl at IMAGE_WIDTH = 8 with a behavioural model of the four line buffers.
module tb_line_buffer_ctrl;

  logic        clk;
  logic        rstN;
  logic [7:0]  i_pixel_data;
  logic        i_pixel_data_valid;
  logic        i_out_ready;
  logic [95:0] lb_rd_data;
  logic [3:0]  lb_data_valid;
  logic [3:0]  lb_rd_enable;
  logic [71:0] o_pixel_data;
  logic        o_pixel_data_valid;
  logic        o_intr;
  logic        o_overflow;

  line_buffer_ctrl #(.IMAGE_WIDTH(8)) dut (
    .clk                (clk),
    .rstN               (rstN),
    .i_pixel_data       (i_pixel_data),
    .i_pixel_data_valid (i_pixel_data_valid),
    .i_out_ready        (i_out_ready),
    .lb_rd_data         (lb_rd_data),
    .lb_data_valid      (lb_data_valid),
    .lb_rd_enable       (lb_rd_enable),
    .o_pixel_data       (o_pixel_data),
    .o_pixel_data_valid (o_pixel_data_valid),
    .o_intr             (o_intr),
    .o_overflow         (o_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External line buffers: write pointer on write enable, read pointer on read enable.
  logic [7:0] mem [4][8];
  logic [2:0] wp [4];
  logic [2:0] rp [4];

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      for (int k = 0; k < 4; k++) begin
        wp[k] <= '0;
        rp[k] <= '0;
      end
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (lb_data_valid[k]) begin
          mem[k][wp[k]] <= i_pixel_data;
          wp[k] <= wp[k] + 3'd1;
        end
        if (lb_rd_enable[k]) rp[k] <= rp[k] + 3'd1;
      end
    end
  end

  always_comb begin
    lb_rd_data = '0;
    for (int k = 0; k < 4; k++) begin
      lb_rd_data[95 - 24*k -: 24] = {mem[k][rp[k]], mem[k][rp[k] + 3'd1], mem[k][rp[k] + 3'd2]};
    end
  end

  int n_checks = 0;
  int n_fail   = 0;
  logic [71:0] sb_q [$];
  int g_row = 0;
  int g_col = 0;
  int intr_cnt = 0;
  int rd_since = 0;
  logic prev_intr = 1'b0;

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] pv(input int r, input int c);
    return 8'((r * 16 + c) & 255);
  endfunction

  function automatic logic [71:0] win(input int k, input int c);
    logic [71:0] w;
    for (int r = 0; r < 3; r++) begin
      w[71 - 24*r -: 24] = {pv(k + r, c % 8), pv(k + r, (c + 1) % 8), pv(k + r, (c + 2) % 8)};
    end
    return w;
  endfunction

  function automatic logic [3:0] rd_mask(input int n);
    logic [3:0] m;
    m = '0;
    m[n % 4] = 1'b1;
    m[(n + 1) % 4] = 1'b1;
    m[(n + 2) % 4] = 1'b1;
    return m;
  endfunction

  // Monitor: pops expected windows on valid, checks read masks and row pulses.
  always @(negedge clk or negedge rstN) begin
    if (!rstN) begin
      intr_cnt  = 0;
      rd_since  = 0;
      prev_intr = 1'b0;
    end else begin
      if (lb_rd_enable != 4'b0000) begin
        chk("rd_en_mask", 96'(lb_rd_enable), 96'(rd_mask(intr_cnt)));
        chk("rd_en_ready", 96'(i_out_ready), 96'(1));
        rd_since++;
      end
      if (o_pixel_data_valid) begin
        if (sb_q.size() == 0) begin
          chk("sb_unexpected_window", 96'(o_pixel_data_valid), 96'(0));
        end else begin
          chk("window", 96'(o_pixel_data), 96'(sb_q.pop_front()));
        end
      end
      if (o_intr) begin
        chk("reads_per_row", 96'(rd_since), 96'(8));
        chk("intr_single_cycle", 96'(prev_intr), 96'(0));
        intr_cnt++;
        rd_since = 0;
      end
      prev_intr = o_intr;
    end
  end

  task automatic put_pixel(input logic rdy);
    logic [3:0] m;
    @(posedge clk); #1;
    i_pixel_data       = pv(g_row, g_col);
    i_pixel_data_valid = 1'b1;
    i_out_ready        = rdy;
    #1;
    m = 4'b0001 << (g_row % 4);
    chk("lb_data_valid", 96'(lb_data_valid), 96'(m));
    g_col++;
    if (g_col == 8) begin
      g_col = 0;
      g_row++;
      if (g_row >= 3) begin
        for (int c = 0; c < 8; c++) sb_q.push_back(win(g_row - 3, c));
      end
    end
  endtask

  task automatic put_row(input logic rdy);
    for (int c = 0; c < 8; c++) put_pixel(rdy);
  endtask

  task automatic idle(input logic rdy);
    @(posedge clk); #1;
    i_pixel_data_valid = 1'b0;
    i_out_ready        = rdy;
    #1;
  endtask

  task automatic wait_intr(input int target);
    for (int i = 0; i < 200 && intr_cnt < target; i++) @(posedge clk);
    #2;
    chk("intr_count", 96'(intr_cnt), 96'(target));
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_o_pixel_data"}, 96'(o_pixel_data), 96'(0));
    chk({tag, "_o_valid"}, 96'(o_pixel_data_valid), 96'(0));
    chk({tag, "_o_intr"}, 96'(o_intr), 96'(0));
    chk({tag, "_o_overflow"}, 96'(o_overflow), 96'(0));
    chk({tag, "_lb_rd_enable"}, 96'(lb_rd_enable), 96'(0));
    chk({tag, "_lb_data_valid"}, 96'(lb_data_valid), 96'(0));
  endtask

  task automatic do_reset();
    rstN = 1'b0;
    i_pixel_data_valid = 1'b0;
    i_out_ready = 1'b0;
    sb_q.delete();
    g_row = 0;
    g_col = 0;
    repeat (2) @(posedge clk);
    #1;
    rstN = 1'b1;
  endtask

  initial begin
    rstN = 1'b0;
    i_pixel_data = '0;
    i_pixel_data_valid = 1'b0;
    i_out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("rst");
    @(posedge clk); #1;
    rstN = 1'b1;

    // Rows 0..3 back to back; consumption 0 reads lb0..lb2.
    for (int r = 0; r < 4; r++) put_row(1'b1);
    idle(1'b1);
    wait_intr(1);
    // Row 4 lands in lb0 while lb1..lb3 are read.
    put_row(1'b1);
    idle(1'b1);
    wait_intr(3);

    // Simultaneous write/read, then a 3-cycle stall.
    put_row(1'b0);
    idle(1'b0);
    idle(1'b0);
    chk("total_before_simul", 96'(dut.total_cnt), 96'(24));
    put_pixel(1'b1);
    for (int i = 0; i < 3; i++) begin
      idle(1'b0);
      chk("total_simul", 96'(dut.total_cnt), 96'(24));
      chk("rd_cnt_frozen", 96'(dut.rd_cnt), 96'(1));
      chk("held_window", 96'(o_pixel_data), 96'(win(3, 0)));
      if (i > 0) chk("valid_stall", 96'(o_pixel_data_valid), 96'(0));
    end
    for (int c = 1; c < 8; c++) put_pixel(1'b1);
    idle(1'b1);
    wait_intr(5);

    // Toggled ready across a full row.
    put_row(1'b0);
    for (int i = 0; i < 24; i++) idle(1'(i % 2));
    idle(1'b1);
    wait_intr(6);
    chk("sb_drained", 96'(sb_q.size()), 96'(0));

    // Reset in the middle of a row being read.
    put_row(1'b0);
    repeat (3) idle(1'b1);
    #2;
    rstN = 1'b0;
    #1;
    check_reset_outputs("midrst");
    chk("midrst_total", 96'(dut.total_cnt), 96'(0));
    do_reset();
    put_pixel(1'b0);
    repeat (3) idle(1'b0);
    chk("no_intr_after_rst", 96'(intr_cnt), 96'(0));

    // Overflow: 33 writes with no reads.
    do_reset();
    for (int i = 0; i < 33; i++) put_pixel(1'b0);
    chk("ovf_before", 96'(o_overflow), 96'(0));
    chk("total_full", 96'(dut.total_cnt), 96'(32));
    idle(1'b0);
    chk("ovf_set", 96'(o_overflow), 96'(1));
    chk("total_sat", 96'(dut.total_cnt), 96'(32));
    repeat (3) idle(1'b0);
    chk("ovf_sticky", 96'(o_overflow), 96'(1));
    do_reset();
    #1;
    chk("ovf_cleared", 96'(o_overflow), 96'(0));

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
